// File: rtl/card_pkg.sv
// Shared card types, constants, FSM state encoding and the baccarat point
// lookup used by the hand dealer and its card counter.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_MAX   = 4'd13;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // Aces through nines count face value; tens, court cards and empty slots count zero.
  function automatic logic [3:0] card_points(input card_t c);
    if ((c >= 4'd1) && (c <= 4'd9)) begin
      return c;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running card source: steps 1..13 on every edge and wraps back to 1,
// so the value captured depends on the edge a request lands on.
module card_counter
  import card_pkg::*;
#(
  parameter int SEED = 1
) (
  input  logic  slow_clock_i,
  input  logic  reset_i,
  output card_t count_o
);

  card_t count_q;

  // NOTE: sequential state is written with non-blocking (<=) assignments so every
  // register samples pre-edge values and the simulation order of blocks cannot matter.
  always_ff @(posedge slow_clock_i) begin
    if (reset_i) begin
      count_q <= card_t'(SEED);
    end else if ((count_q == CARD_EMPTY) || (count_q >= CARD_MAX)) begin
      // Covers both the normal 13 -> 1 wrap and recovery from any illegal value.
      count_q <= 4'd1;
    end else begin
      count_q <= count_q + 4'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hand_dealer.sv
// Three-slot card hand: captures the running counter value on a request,
// acknowledges with a one-cycle pulse, and reports the baccarat score.
module hand_dealer
  import card_pkg::*;
#(
  parameter int SEED = 1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       clear_hand,
  output logic       deal_ack,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [1:0] num_cards,
  output logic       hand_full,
  output logic [3:0] score
);

  card_t       count;
  state_e      state_q, state_d;
  logic        capture;
  card_t       card1_q, card2_q, card3_q;
  logic [1:0]  num_q;
  logic [4:0]  sum;
  logic [4:0]  sum_mod;

  card_counter #(.SEED(SEED)) u_counter (
    .slow_clock_i (slow_clock),
    .reset_i      (reset),
    .count_o      (count)
  );

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-edge clear beats the capture: nothing is stored and no ack follows.
        if (deal_req && !hand_full && !clear_hand) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!deal_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset || clear_hand) begin
      card1_q <= CARD_EMPTY;
      card2_q <= CARD_EMPTY;
      card3_q <= CARD_EMPTY;
      num_q   <= 2'd0;
    end else if (capture) begin
      unique case (num_q)
        2'd0:    card1_q <= count;
        2'd1:    card2_q <= count;
        default: card3_q <= count;
      endcase
      num_q <= num_q + 2'd1;
    end
  end

  // Largest possible sum is 9+9+9 = 27, so two conditional subtractions replace a divider.
  always_comb begin
    sum = 5'(card_points(card1_q)) + 5'(card_points(card2_q)) + 5'(card_points(card3_q));
    if (sum >= 5'd20) begin
      sum_mod = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum_mod = sum - 5'd10;
    end else begin
      sum_mod = sum;
    end
  end

  assign deal_ack  = (state_q == ACK);
  assign card1     = card1_q;
  assign card2     = card2_q;
  assign card3     = card3_q;
  assign num_cards = num_q;
  assign hand_full = (num_q == 2'd3);
  assign score     = sum_mod[3:0];

endmodule

// File: tb/tb_hand_dealer.sv
// Scoreboard bench for hand_dealer: each expected deal is queued when the
// request is issued and checked by a monitor whenever deal_ack is seen.
module tb_hand_dealer;

  logic       slow_clock;
  logic       reset;
  logic       deal_req;
  logic       clear_hand;
  logic       deal_ack;
  logic [3:0] card1, card2, card3;
  logic [1:0] num_cards;
  logic       hand_full;
  logic [3:0] score;

  typedef struct {
    int c1;
    int c2;
    int c3;
    int n;
    int full;
    int score;
  } exp_t;

  exp_t sb[$];
  int   passed  = 0;
  int   total   = 0;
  int   ack_cnt = 0;
  int   e       = 0;

  hand_dealer #(.SEED(1)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .deal_req   (deal_req),
    .clear_hand (clear_hand),
    .deal_ack   (deal_ack),
    .card1      (card1),
    .card2      (card2),
    .card3      (card3),
    .num_cards  (num_cards),
    .hand_full  (hand_full),
    .score      (score)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act === req) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge slow_clock) begin
    if (deal_ack === 1'b1) begin
      exp_t x;
      ack_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        x = sb.pop_front();
        check("ack_card1", int'(card1), x.c1);
        check("ack_card2", int'(card2), x.c2);
        check("ack_card3", int'(card3), x.c3);
        check("ack_num_cards", int'(num_cards), x.n);
        check("ack_hand_full", int'(hand_full), x.full);
        check("ack_score", int'(score), x.score);
      end
    end
  end

  // One clock cycle; inputs change just after the falling edge.
  task automatic step();
    @(negedge slow_clock);
    #1;
    e++;
  endtask

  // After this returns, the next rising edge is edge 1 and the counter holds SEED.
  task automatic do_reset();
    reset      = 1'b1;
    deal_req   = 1'b0;
    clear_hand = 1'b0;
    step();
    step();
    reset = 1'b0;
    e     = 0;
  endtask

  // Request sampled at edge k; returns in the cycle where deal_ack should be high.
  task automatic deal_at(input int k, input exp_t x);
    while (e < k - 1) step();
    sb.push_back(x);
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int c1, input int c2, input int c3,
                               input int n, input int full, input int sc);
    check({tag, "_card1"}, int'(card1), c1);
    check({tag, "_card2"}, int'(card2), c2);
    check({tag, "_card3"}, int'(card3), c3);
    check({tag, "_num_cards"}, int'(num_cards), n);
    check({tag, "_hand_full"}, int'(hand_full), full);
    check({tag, "_score"}, int'(score), sc);
  endtask

  initial begin
    int acks_before;
    reset      = 1'b1;
    deal_req   = 1'b0;
    clear_hand = 1'b0;

    // Reset state
    do_reset();
    check("reset_deal_ack", int'(deal_ack), 0);
    check_outputs("reset", 0, 0, 0, 0, 0, 0);

    // Three deals at edges 1, 5, 9
    deal_at(1, '{1, 0, 0, 1, 0, 1});
    deal_at(5, '{1, 5, 0, 2, 0, 6});
    deal_at(9, '{1, 5, 9, 3, 1, 5});

    // Full hand: requests are ignored
    step();
    step();
    acks_before = ack_cnt;
    deal_req = 1'b1;
    repeat (5) step();
    deal_req = 1'b0;
    step();
    check("full_no_ack", ack_cnt, acks_before);
    check_outputs("full_hold", 1, 5, 9, 3, 1, 5);

    // Counter wrap: edges 13 and 16
    do_reset();
    deal_at(13, '{13, 0, 0, 1, 0, 0});
    deal_at(16, '{13, 3, 0, 2, 0, 3});

    // Edges 12 and 15
    do_reset();
    deal_at(12, '{12, 0, 0, 1, 0, 0});
    deal_at(15, '{12, 2, 0, 2, 0, 2});

    // Held request gives exactly one ack; next card only after a low sample
    do_reset();
    acks_before = ack_cnt;
    sb.push_back('{1, 0, 0, 1, 0, 1});
    deal_req = 1'b1;
    repeat (6) step();
    check("held_one_ack", ack_cnt, acks_before + 1);
    check("held_num_cards", int'(num_cards), 1);
    deal_req = 1'b0;
    step();
    deal_at(8, '{1, 8, 0, 2, 0, 9});

    // Clear wins over a same-edge capture
    do_reset();
    deal_at(1, '{1, 0, 0, 1, 0, 1});
    deal_at(5, '{1, 5, 0, 2, 0, 6});
    step();
    step();
    acks_before = ack_cnt;
    clear_hand = 1'b1;
    deal_req   = 1'b1;
    step();
    clear_hand = 1'b0;
    deal_req   = 1'b0;
    check("clear_deal_ack", int'(deal_ack), 0);
    check_outputs("clear", 0, 0, 0, 0, 0, 0);
    step();
    check("clear_no_ack", ack_cnt, acks_before);

    // Reset during ACK aborts the handshake
    do_reset();
    deal_at(1, '{1, 0, 0, 1, 0, 1});
    reset = 1'b1;
    step();
    check("abort_deal_ack", int'(deal_ack), 0);
    check_outputs("abort", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    e     = 0;
    deal_at(1, '{1, 0, 0, 1, 0, 1});
    step();

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
